// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between an issuing master and the shift_sequencer.
// The master offers operations; the slave (sequencer) returns registered results.
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_err;

  modport master (
    output in_valid, op, a, amt, out_ready,
    input  in_ready, out_valid, result, out_err
  );

  modport slave (
    input  in_valid, op, a, amt, out_ready,
    output in_ready, out_valid, result, out_err
  );
endinterface

// File: rtl/shift_sequencer.sv
// Issue/collect FSM around an external combinational 32-bit barrel shifter.
// Rotates are built from two shifter passes whose partial results are OR-ed.
module shift_sequencer (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus,
  output logic [31:0]       sh_in,
  output logic [4:0]        sh_amt,
  output logic              sh_dir,
  output logic              sh_signex,
  input  logic [31:0]       sh_out
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [4:0]  amt_q, amt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] p1_q, p1_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        is_rot;

  // Complementary amount for the second rotate pass: 5-bit two's-complement negate.
  function automatic logic [4:0] neg_amt(input logic [4:0] x);
    return ~x + 5'd1;
  endfunction

  assign is_rot = (op_q == OP_ROL) || (op_q == OP_ROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      amt_q    <= '0;
      op_q     <= '0;
      p1_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      amt_q    <= amt_d;
      op_q     <= op_d;
      p1_q     <= p1_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    amt_d     = amt_q;
    op_d      = op_q;
    p1_d      = p1_q;
    result_d  = result_q;
    err_d     = err_q;
    sh_in     = '0;
    sh_amt    = '0;
    sh_dir    = 1'b0;
    sh_signex = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.a;
          amt_d = bus.amt;
          op_d  = bus.op;
          if (bus.op > OP_ROR) begin
            result_d = bus.a;
            err_d    = 1'b1;
            state_d  = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = PASS1;
          end
        end
      end
      PASS1: begin
        sh_in     = a_q;
        sh_amt    = amt_q;
        sh_dir    = (op_q != OP_SLL) && (op_q != OP_ROL);
        sh_signex = (op_q == OP_SRA);
        p1_d      = sh_out;
        // A rotate by zero is complete after the first pass.
        if (is_rot && (amt_q != 5'd0)) begin
          state_d = PASS2;
        end else begin
          result_d = sh_out;
          state_d  = DONE;
        end
      end
      PASS2: begin
        sh_in    = a_q;
        sh_amt   = neg_amt(amt_q);
        sh_dir   = (op_q == OP_ROL);
        result_d = p1_q | sh_out;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural barrel shifter on the sh_* loop.
module tb_shift_sequencer;
  logic        clk;
  logic        rst_n;
  logic [31:0] sh_in;
  logic [4:0]  sh_amt;
  logic        sh_dir;
  logic        sh_signex;
  logic [31:0] sh_out;
  int          checks;
  int          errors;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sh_in     (sh_in),
    .sh_amt    (sh_amt),
    .sh_dir    (sh_dir),
    .sh_signex (sh_signex),
    .sh_out    (sh_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sh_out = sh_in << sh_amt;
    if (sh_dir) begin
      if (sh_signex) sh_out = $unsigned($signed(sh_in) >>> sh_amt);
      else           sh_out = sh_in >> sh_amt;
    end
  end

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] av,
                                            input logic [4:0] am);
    logic [63:0] t;
    logic [63:0] r;
    t = {av, av};
    case (o)
      3'd0: return av << am;
      3'd1: return av >> am;
      3'd2: return $unsigned($signed(av) >>> am);
      3'd3: begin r = t << am; return r[63:32]; end
      3'd4: begin r = t >> am; return r[31:0]; end
      default: return av;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [4:0] am);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got in_ready=%0b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = av;
    bus.amt      = am;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.amt       = '0;
    bus.out_ready = 1'b1;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/vld/err=%b want 100",
               {bus.in_ready, bus.out_valid, bus.out_err});
    end
    checks++;
    if (bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 00000000", bus.result);
    end
    checks++;
    if ({sh_in, sh_amt, sh_dir, sh_signex} !== 39'h0) begin
      errors++;
      $display("FAIL reset_sh got in=%h amt=%0d dir=%0b sx=%0b want all 0",
               sh_in, sh_amt, sh_dir, sh_signex);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_shifts;
    logic [2:0]  ops [3] = '{3'd2, 3'd1, 3'd0};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    logic [4:0]  ams [3] = '{5'd4, 5'd4, 5'd31};
    logic [31:0] exp [3] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000};
    int c;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], ams[i]);
      wait_valid(c);
      checks++;
      if (c !== 1) begin
        errors++;
        $display("FAIL shift_latency op=%0d got %0d want 1", ops[i], c);
      end
      checks++;
      if (bus.result !== exp[i] || bus.out_err !== 1'b0) begin
        errors++;
        $display("FAIL shift_result op=%0d got %h err=%0b want %h err=0",
                 ops[i], bus.result, bus.out_err, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rotates;
    int c;
    issue(3'd4, 32'h0000_00F1, 5'd4);
    checks++;
    if (sh_amt !== 5'd4 || sh_dir !== 1'b1 || sh_in !== 32'hF1) begin
      errors++;
      $display("FAIL ror_pass1 got amt=%0d dir=%0b in=%h want 4 1 000000f1", sh_amt, sh_dir, sh_in);
    end
    @(negedge clk);
    checks++;
    if (sh_amt !== 5'd28 || sh_dir !== 1'b0 || sh_signex !== 1'b0 || sh_in !== 32'hF1) begin
      errors++;
      $display("FAIL ror_pass2 got amt=%0d dir=%0b sx=%0b in=%h want 28 0 0 000000f1",
               sh_amt, sh_dir, sh_signex, sh_in);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h1000_000F) begin
      errors++;
      $display("FAIL ror_result got vld=%0b res=%h want 1 1000000f", bus.out_valid, bus.result);
    end
    @(negedge clk);
    issue(3'd3, 32'h8000_0001, 5'd1);
    wait_valid(c);
    checks++;
    if (c !== 2 || bus.result !== 32'h0000_0003) begin
      errors++;
      $display("FAIL rol1 got lat=%0d res=%h want 2 00000003", c, bus.result);
    end
    @(negedge clk);
    issue(3'd3, 32'hDEAD_BEEF, 5'd0);
    wait_valid(c);
    checks++;
    if (c !== 1 || bus.result !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rol0 got lat=%0d res=%h want 1 deadbeef", c, bus.result);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int c;
    bus.out_ready = 1'b0;
    issue(3'd0, 32'h0000_0001, 5'd31);
    wait_valid(c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h8000_0000) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got vld=%0b rdy=%0b res=%h want 1 0 80000000",
                 i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd1;
    bus.a         = 32'hFFFF_0000;
    bus.amt       = 5'd8;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake_rdy got %0b want 0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%0b vld=%0b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(c);
    checks++;
    if (c !== 1 || bus.result !== 32'h00FF_FF00) begin
      errors++;
      $display("FAIL bp_next got lat=%0d res=%h want 1 00ffff00", c, bus.result);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int c;
    issue(3'd6, 32'h1234_5678, 5'd7);
    wait_valid(c);
    checks++;
    if (c !== 0 || bus.result !== 32'h1234_5678 || bus.out_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal got lat=%0d res=%h err=%0b want 0 12345678 1", c, bus.result, bus.out_err);
    end
    checks++;
    if ({sh_in, sh_amt, sh_dir, sh_signex} !== 39'h0) begin
      errors++;
      $display("FAIL illegal_sh got in=%h amt=%0d dir=%0b sx=%0b want all 0",
               sh_in, sh_amt, sh_dir, sh_signex);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int c;
    issue(3'd4, 32'hA5A5_0F0F, 5'd12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0 || sh_amt !== 5'd0) begin
      errors++;
      $display("FAIL midreset got vld=%0b rdy=%0b res=%h shamt=%0d want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.result, sh_amt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_quiet cyc=%0d got vld=%0b rdy=%0b want 0 1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
    issue(3'd1, 32'hF000_0000, 5'd28);
    wait_valid(c);
    checks++;
    if (c !== 1 || bus.result !== 32'h0000_000F) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d res=%h want 1 0000000f", c, bus.result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] expq[$];
    logic [2:0]  o;
    logic [31:0] av;
    logic [4:0]  am;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    o  = 3'($urandom_range(0, 4));
    av = $urandom;
    am = 5'($urandom_range(0, 31));
    bus.op = o; bus.a = av; bus.amt = am;
    bus.in_valid = 1'b1;
    while (got < 20 && cyc < 300) begin
      if (bus.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got res=%h want no output", bus.result);
        end else begin
          if (bus.result !== expq[0] || bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result idx=%0d got %h err=%0b want %h err=0",
                     got, bus.result, bus.out_err, expq[0]);
          end
          void'(expq.pop_front());
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_model(o, av, am));
        sent++;
        @(posedge clk);
        #1;
        if (sent < 20) begin
          o  = 3'($urandom_range(0, 4));
          av = $urandom;
          am = 5'($urandom_range(0, 31));
          bus.op = o; bus.a = av; bus.amt = am;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got !== 20 || expq.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count got %0d outputs pending=%0d want 20 pending=0", got, expq.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_shifts();
    test_rotates();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequential issue/collect stage wrapped around the datapath's combinational 32-bit barrel shifter. It accepts shift and rotate operations over a valid/ready handshake and drives the barrel shifter's operand, amount, direction and sign-extension inputs. It captures the shifter output, building rotates from two passes through the single shifter, and presents a registered result downstream over a valid/ready handshake.

## Interface
Parameters: none (the datapath is fixed at 32 bits and the amount at 5 bits, matching the barrel shifter).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  the block can accept a request
- op  in  3  operation code:
  - 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR
  - 101–111 illegal
- a  in  32  operand
- amt  in  5  shift amount, 0–31
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- result  out  32  operation result
- out_err  out  1  the op was illegal; qualified by out_valid
- sh_in  out  32  to barrel shifter data input
- sh_amt  out  5  to barrel shifter shift amount
- sh_dir  out  1  to barrel shifter direction; 0 = left, 1 = right
- sh_signex  out  1  to barrel shifter; 1 = right shift fills with sh_in[31]
- sh_out  in  32  from barrel shifter output; combinational function of the sh_* outputs

## Operation
- States:
  - IDLE: in_ready=1.
  - PASS1, PASS2: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: when in_valid && in_ready in IDLE, register a, amt and op, then go to PASS1.
- Illegal op: go directly to DONE with result=a and out_err=1.
- sh_* drive:
  - sh_* are registered-operand driven and valid only in PASS1 and PASS2.
  - In IDLE and DONE all sh_* outputs are 0.
- PASS1:
  - sh_in=a_q and sh_amt=amt_q.
  - SLL, ROL: sh_dir=0.
  - SRL, SRA, ROR: sh_dir=1.
  - sh_signex=1 only for SRA.
  - Capture sh_out into p1 at the clock edge.
  - SLL, SRL, SRA, and rotate with amt_q==0: result=sh_out, then go to DONE.
  - Rotate with amt_q!=0: go to PASS2.
- PASS2:
  - sh_in=a_q.
  - sh_amt = (~amt_q + 1) mod 32, which equals 32−amt_q for amt_q in 1..31.
  - sh_dir is the opposite of PASS1; sh_signex=0.
  - result = p1 | sh_out, then go to DONE.
- DONE: hold result and out_err stable until out_valid && out_ready, then go to IDLE. out_err=0 for legal ops.
- Arithmetic: all values are unsigned 32-bit, with no carries. Only the 5-bit two's-complement negate above is used for the complementary amount.

## Timing
- Reset (asynchronous, immediate), all fixed while rst_n=0:
  - state=IDLE, in_ready=1.
  - out_valid=0, out_err=0, result=0x00000000.
  - p1=0 and all sh_* outputs=0.
- Reset mid-operation (PASS1, PASS2 or DONE): the in-flight op is discarded with no output. After release, the first rising edge with in_valid=1 accepts a new request.
- Latency, counted from the accept edge at cycle T (the edge where in_valid && in_ready):
  - Single-pass op (including rotate by 0): out_valid rises after edge T+1.
  - Rotate with amt!=0: out_valid rises after edge T+2.
  - Illegal op: out_valid rises after edge T.
- Throughput:
  - One op in flight at a time; in_ready stays 0 from the accept edge until the DONE→IDLE edge.
  - The earliest next accept is the cycle after the output handshake.
- Backpressure: with out_ready=0, DONE holds indefinitely and result does not change.
- In a cycle with out_valid && out_ready, in_ready is still 0; an input offered in that cycle is not accepted.
- sh_out must settle within one cycle of the sh_* outputs. The block adds no pipeline register between sh_* and sh_out.

## Test plan
- Reset: assert rst_n=0 mid-PASS2 of a ROR, then release. Required: out_valid=0, in_ready=1, result=0 immediately, and the aborted op never appears on the output.
- SRA: a=0x80000000, amt=4. Required: out_valid 2 cycles after accept, result=0xF8000000, out_err=0. SRL with the same inputs must give 0x08000000. SLL a=0x00000001, amt=31 must give 0x80000000.
- Rotates:
  - ROR a=0x000000F1, amt=4 must give result=0x1000000F after 3 cycles. PASS2 must drive sh_amt=28 with sh_dir=0.
  - ROL a=0x80000001, amt=1 must give 0x00000003.
  - ROL with amt=0 must give result=a after 2 cycles.
- Backpressure: complete an op with out_ready held 0 for 5 cycles. Required: out_valid and result stable throughout, and in_ready=0 throughout. Raising out_ready must complete the handshake; in_ready=1 on the next cycle.
- Illegal op: op=110, a=0x12345678. Required: out_valid after 1 cycle, result=0x12345678, out_err=1. sh_* must stay 0 throughout.
- Back-to-back: issue 20 random legal ops with in_valid held high and out_ready=1. Required: every result matches the reference model, in order, with no drop or duplication.
